mem_access_unit: RTL

//  Processor-side initiator for the byte-addressed, big-endian data memory port.

---
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for a byte-addressed, big-endian, word-wide data memory.
// Sub-word stores are done as read-modify-write because the memory always writes a full word.
module mem_access_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int MEM_BYTES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [WORD_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [WORD_WIDTH-1:0] data_addr,
    output logic                  data_wr,
    output logic [WORD_WIDTH-1:0] data_out,
    input  logic [WORD_WIDTH-1:0] data_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t      state_r;
    logic        wr_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [1:0]  offset_r;
    logic [15:0] wdata_r;
    logic        accept_s;
    logic        err_s;

    // Select the addressed lane of a memory word and extend it to a full word.
    function automatic logic [WORD_WIDTH-1:0] extract_load(
        input logic [WORD_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            off,
        input logic                  sgn
    );
        logic [7:0]            lane_b;
        logic [15:0]           lane_h;
        logic [WORD_WIDTH-1:0] res;
        lane_b = 8'h00;
        lane_h = 16'h0000;
        res    = 32'h0000_0000;
        case (off)
            2'd0:    lane_b = word[31:24];
            2'd1:    lane_b = word[23:16];
            2'd2:    lane_b = word[15:8];
            default: lane_b = word[7:0];
        endcase
        lane_h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = {{24{sgn & lane_b[7]}}, lane_b};
            2'b01:   res = {{16{sgn & lane_h[15]}}, lane_h};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of a memory word with right-justified store data.
    function automatic logic [WORD_WIDTH-1:0] merge_store(
        input logic [WORD_WIDTH-1:0] word,
        input logic [1:0]            size,
        input logic [1:0]            off,
        input logic [15:0]           wd
    );
        logic [WORD_WIDTH-1:0] res;
        res = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    res[31:24] = wd[7:0];
                    2'd1:    res[23:16] = wd[7:0];
                    2'd2:    res[15:8]  = wd[7:0];
                    default: res[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) begin
                    res[15:0] = wd;
                end else begin
                    res[31:16] = wd;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Request acceptance and the access-legality check on the incoming request.
    always_comb begin
        accept_s = req_valid && req_ready;
        err_s    = 1'b0;
        if (req_size == 2'b11) begin
            err_s = 1'b1;
        end else if ((req_size == 2'b01) && req_addr[0]) begin
            err_s = 1'b1;
        end else if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else if (req_addr >= WORD_WIDTH'(MEM_BYTES)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Gate the write strobe with reset so no memory write can happen while reset is held.
    assign data_wr = (state_r == WR) && !rst;

    // Access sequencer: all outputs except the write strobe are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            data_addr <= 32'h0000_0000;
            data_out  <= 32'h0000_0000;
            wr_r      <= 1'b0;
            size_r    <= 2'b00;
            signed_r  <= 1'b0;
            offset_r  <= 2'b00;
            wdata_r   <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wr_r      <= req_wr;
                        size_r    <= req_size;
                        signed_r  <= req_signed;
                        offset_r  <= req_addr[1:0];
                        wdata_r   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (err_s) begin
                            state_r   <= RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else if (req_wr && (req_size == 2'b10)) begin
                            state_r   <= WR;
                            data_addr <= {req_addr[WORD_WIDTH-1:2], 2'b00};
                            data_out  <= req_wdata;
                        end else begin
                            state_r   <= RD;
                            data_addr <= {req_addr[WORD_WIDTH-1:2], 2'b00};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    // The read word is consumed straight from data_in at the end of RD.
                    if (wr_r) begin
                        state_r  <= WR;
                        data_out <= merge_store(data_in, size_r, offset_r, wdata_r);
                    end else begin
                        state_r   <= RSP;
                        data_addr <= 32'h0000_0000;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= extract_load(data_in, size_r, offset_r, signed_r);
                    end
                end
                WR: begin
                    state_r   <= RSP;
                    data_addr <= 32'h0000_0000;
                    data_out  <= 32'h0000_0000;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                end
                RSP: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                    data_addr <= 32'h0000_0000;
                    data_out  <= 32'h0000_0000;
                end
            endcase
        end
    end

endmodule
